fpu_issue_scoreboard: RTL and testbench

- Sits between the integer core's decode stage and the FPU's instruction input.
- Holds each FP instruction until no older in-flight FP instruction still owes a write to one of its source float registers.
- The FPU has no forwarding, and every float-register write lands a fixed number of cycles after issue. This block therefore tracks in-flight destinations in a shift pipeline that mirrors the FPU's rd pipeline, and issues at most one instruction per cycle.

---
 rtl/fpu_pkg.sv | 46 ++++
 rtl/fpu_issue_scoreboard_pipe.sv | 50 +++++
 rtl/fpu_issue_scoreboard.sv | 68 ++++++
 tb/tb_fpu_issue_scoreboard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: register geometry, writeback depth,
// pending-write slot layout and the decode opcode classes.
package fpu_pkg;

  localparam int FREG_W       = 5;
  localparam int FPU_WB_DEPTH = 5;

  typedef struct packed {
    logic              v;
    logic [FREG_W-1:0] rd;
  } fpu_slot_t;

  typedef enum logic [2:0] {
    FOP_LOAD,
    FOP_STORE,
    FOP_ADD,
    FOP_SUB,
    FOP_MUL,
    FOP_ITOF,
    FOP_FTOI
  } fpu_op_e;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wr_freg;
  } fpu_opuse_t;

  // Register usage per class; store data travels on rs2
  function automatic fpu_opuse_t fpu_op_use(fpu_op_e op);
    fpu_opuse_t u;
    u = '0;
    case (op)
      FOP_LOAD:  u = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_freg: 1'b1};
      FOP_STORE: u = '{use_rs1: 1'b0, use_rs2: 1'b1, wr_freg: 1'b0};
      FOP_ADD,
      FOP_SUB,
      FOP_MUL:   u = '{use_rs1: 1'b1, use_rs2: 1'b1, wr_freg: 1'b1};
      FOP_ITOF:  u = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_freg: 1'b1};
      FOP_FTOI:  u = '{use_rs1: 1'b1, use_rs2: 1'b0, wr_freg: 1'b0};
      default:   u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_issue_scoreboard_pipe.sv
// Pending float-register write tracker mirroring the FPU rd pipeline.
// Slot k holds the instruction issued k+1 cycles ago.
module fpu_pending_pipe
  import fpu_pkg::*;
#(
  parameter int DEPTH = FPU_WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push_v,
  input  logic [FREG_W-1:0]      i_push_rd,
  input  logic [FREG_W-1:0]      i_q1,
  input  logic [FREG_W-1:0]      i_q2,
  output logic [DEPTH-1:0]       o_m1,
  output logic [DEPTH-1:0]       o_m2,
  output logic [2**FREG_W-1:0]   o_busy_vec,
  output logic [2:0]             o_inflight
);

  fpu_slot_t r_slot [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      r_slot[0] <= {i_push_v, i_push_rd};
      for (int k = 1; k < DEPTH; k++) begin
        r_slot[k] <= r_slot[k-1];
      end
    end
  end

  always_comb begin
    o_m1       = '0;
    o_m2       = '0;
    o_busy_vec = '0;
    o_inflight = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_m1[k] = r_slot[k].v && (r_slot[k].rd == i_q1);
      o_m2[k] = r_slot[k].v && (r_slot[k].rd == i_q2);
      if (r_slot[k].v) begin
        o_busy_vec[r_slot[k].rd] = 1'b1;
        o_inflight               = o_inflight + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// In-order FP issue gate: holds an instruction while an older one
// still owes a write to one of its sources.
module fpu_issue_scoreboard
  import fpu_pkg::*;
#(
  parameter int WB_DEPTH   = FPU_WB_DEPTH,
  parameter int REG_BYPASS = 0,
  parameter int REG_W      = FREG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic                 in_wr_freg,
  input  logic                 hold,
  output logic                 in_ready,
  output logic                 issue,
  output logic                 hazard,
  output logic [2**REG_W-1:0]  busy_vec,
  output logic [2:0]           inflight
);

  // A write-first regfile lets the oldest slot's write be seen
  localparam int WIN = (REG_BYPASS != 0) ? WB_DEPTH - 1 : WB_DEPTH;

  logic [WB_DEPTH-1:0] w_win;
  logic [WB_DEPTH-1:0] w_m1;
  logic [WB_DEPTH-1:0] w_m2;
  logic [2**REG_W-1:0] w_busy;
  logic [2:0]          w_inflight;
  logic                w_hit1;
  logic                w_hit2;

  always_comb begin
    w_win = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_win[k] = (k < WIN);
    end
  end

  fpu_pending_pipe #(
    .DEPTH (WB_DEPTH)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_push_v   (issue && in_wr_freg),
    .i_push_rd  (in_rd),
    .i_q1       (in_rs1),
    .i_q2       (in_rs2),
    .o_m1       (w_m1),
    .o_m2       (w_m2),
    .o_busy_vec (w_busy),
    .o_inflight (w_inflight)
  );

  assign w_hit1   = in_use_rs1 && |(w_m1 & w_win);
  assign w_hit2   = in_use_rs2 && |(w_m2 & w_win);
  assign hazard   = in_valid && (w_hit1 || w_hit2);
  assign in_ready = !rst && !hold && !hazard;
  assign issue    = in_valid && in_ready;
  assign busy_vec = rst ? '0 : w_busy;
  assign inflight = rst ? '0 : w_inflight;

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Directed checks of the FP issue scoreboard, with and without
// the write-first register file option.
module tb_fpu_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic        in_wr_freg;
  logic        hold;

  logic        ready0, issue0, hazard0;
  logic [31:0] busy0;
  logic [2:0]  infl0;
  logic        ready1, issue1, hazard1;
  logic [31:0] busy1;
  logic [2:0]  infl1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_issue_scoreboard #(
    .WB_DEPTH(5), .REG_BYPASS(0), .REG_W(5)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_wr_freg(in_wr_freg), .hold(hold),
    .in_ready(ready0), .issue(issue0), .hazard(hazard0),
    .busy_vec(busy0), .inflight(infl0)
  );

  fpu_issue_scoreboard #(
    .WB_DEPTH(5), .REG_BYPASS(1), .REG_W(5)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_wr_freg(in_wr_freg), .hold(hold),
    .in_ready(ready1), .issue(issue1), .hazard(hazard1),
    .busy_vec(busy1), .inflight(infl1)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(logic v, int a, int b, int d,
                        logic u1, logic u2, logic wr);
    in_valid   = v;
    in_rs1     = 5'(a);
    in_rs2     = 5'(b);
    in_rd      = 5'(d);
    in_use_rs1 = u1;
    in_use_rs2 = u2;
    in_wr_freg = wr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    set_in(1, 10, 11, 1, 1, 1, 1);
    cyc();
    cyc();
    check("rst_ready", 32'(ready0), 0);
    check("rst_issue", 32'(issue0), 0);
    check("rst_busy", busy0, 0);
    check("rst_infl", 32'(infl0), 0);

    // 1: independent back-to-back issue
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1, 10 + c, 20 + c, 1 + c, 1, 1, 1);
      #1;
      check("s1_issue", 32'(issue0), 1);
      cyc();
      check("s1_infl", 32'(infl0), 32'(c + 1));
    end
    check("s1_busy", busy0, 32'h0000_001E);
    set_in(0, 1, 2, 5, 1, 1, 1);
    #1;
    check("s1_idle_ready", 32'(ready0), 1);
    check("s1_idle_haz", 32'(hazard0), 0);

    // 2/3: RAW on f3, both bypass settings
    do_reset();
    set_in(1, 1, 2, 3, 1, 1, 1);
    #1;
    check("s2_fadd_issue", 32'(issue0), 1);
    check("s3_fadd_issue", 32'(issue1), 1);
    cyc();
    for (int cy = 1; cy <= 6; cy++) begin
      set_in(1, 3, 4, 5, 1, 1, 1);
      #1;
      check("s2_haz", 32'(hazard0), 32'(cy <= 5));
      check("s2_issue", 32'(issue0), 32'(cy == 6));
      check("s2_busy3", 32'(busy0[3]), 32'(cy <= 5));
      if (cy <= 5) begin
        check("s3_haz", 32'(hazard1), 32'(cy <= 4));
        check("s3_issue", 32'(issue1), 32'(cy == 5));
      end
      if (cy == 5) check("s3_busy3", 32'(busy1[3]), 1);
      cyc();
    end

    // 4: store reads rs2 only
    do_reset();
    set_in(1, 0, 0, 7, 0, 0, 1);
    #1;
    check("s4_load_issue", 32'(issue0), 1);
    cyc();
    for (int cy = 1; cy <= 6; cy++) begin
      set_in(1, 7, 7, 0, 0, 1, 0);
      #1;
      check("s4_haz", 32'(hazard0), 32'(cy <= 5));
      check("s4_issue", 32'(issue0), 32'(cy == 6));
      cyc();
    end
    do_reset();
    set_in(1, 0, 0, 7, 0, 0, 1);
    cyc();
    set_in(1, 7, 8, 0, 0, 1, 0);
    #1;
    check("s4_free_issue", 32'(issue0), 1);
    check("s4_free_haz", 32'(hazard0), 0);

    // 5: external hold, alone and with a hazard
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(1, 10, 11, c + 1, 1, 1, 1);
      #1;
      check("s5_fill_issue", 32'(issue0), 1);
      cyc();
    end
    hold = 1'b1;
    set_in(1, 10, 11, 9, 1, 1, 1);
    #1;
    check("s5_hold_issue", 32'(issue0), 0);
    check("s5_hold_ready", 32'(ready0), 0);
    check("s5_hold_infl", 32'(infl0), 5);
    cyc();
    check("s5_hold2_issue", 32'(issue0), 0);
    check("s5_hold2_infl", 32'(infl0), 4);
    cyc();
    hold = 1'b0;
    #1;
    check("s5_rel_issue", 32'(issue0), 1);
    check("s5_rel_infl", 32'(infl0), 3);
    cyc();
    hold = 1'b1;
    set_in(1, 9, 11, 12, 1, 1, 1);
    #1;
    check("s5_hh_haz", 32'(hazard0), 1);
    check("s5_hh_issue", 32'(issue0), 0);
    check("s5_hh_infl", 32'(infl0), 3);
    cyc();
    hold = 1'b0;
    #1;
    check("s5_hh_after_infl", 32'(infl0), 2);
    check("s5_hh_after_haz", 32'(hazard0), 1);

    // 6: reset while a dependent instruction waits
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 10, 11, c + 1, 1, 1, 1);
      cyc();
    end
    set_in(1, 2, 11, 13, 1, 1, 1);
    #1;
    check("s6_dep_haz", 32'(hazard0), 1);
    check("s6_dep_infl", 32'(infl0), 3);
    check("s6_dep_issue", 32'(issue0), 0);
    rst = 1'b1;
    #1;
    check("s6_rst_ready", 32'(ready0), 0);
    check("s6_rst_issue", 32'(issue0), 0);
    check("s6_rst_busy", busy0, 0);
    check("s6_rst_infl", 32'(infl0), 0);
    cyc();
    rst = 1'b0;
    #1;
    check("s6_post_busy", busy0, 0);
    check("s6_post_infl", 32'(infl0), 0);
    check("s6_post_haz", 32'(hazard0), 0);
    check("s6_post_issue", 32'(issue0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
